// File: rtl/uart_probe_fmt_if.sv
// Byte-stream handshake between uart_probe_fmt and the downstream uart_tx.
// The master drives data/valid; the slave answers with ready.
interface uart_probe_fmt_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_probe_fmt.sv
// Label/width-generic probe snapshot formatter emitting ASCII frames "L:HHH ... \r\n".
// Optional macro UART_PROBE_DELTA_EN: periodic ticks print only when the probe value changed.
module uart_probe_fmt #(
  parameter int unsigned         NUM_CH = 8,
  parameter int unsigned         CH_HEX = 4,
  parameter int unsigned         PERIOD = 27000000,
  parameter logic [8*NUM_CH-1:0] LABELS = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       trig,
  input  logic [NUM_CH*CH_HEX*4-1:0] probe,
  uart_probe_fmt_if.master           tx,
  output logic                       busy,
  output logic [7:0]                 overrun_cnt
);
  localparam int unsigned PW = NUM_CH * CH_HEX * 4;
  localparam int unsigned TW = $clog2(PERIOD);
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DW = (CH_HEX > 1) ? $clog2(CH_HEX) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(PERIOD - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);
  localparam logic [DW-1:0] DIG_TOP   = DW'(CH_HEX - 1);

  typedef enum logic [2:0] {IDLE, LABEL, COLON, DIGIT, SEP, LF} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [PW-1:0] snap_q;
  logic [TW-1:0] timer_q;
  logic          tick, req, start, accept;
  logic [3:0]    nib;
  logic [7:0]    label, hex_char, data;

  assign tick = (timer_q == TIMER_MAX) && enable;

`ifdef UART_PROBE_DELTA_EN
  // snap_q always holds the last transmitted snapshot; primed_q forces the first print.
  logic primed_q;
  assign req = trig || (tick && (!primed_q || (probe != snap_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     primed_q <= 1'b0;
    else if (start) primed_q <= 1'b1;
  end
`else
  assign req = tick || trig;
`endif

  assign start  = req && (state_q == IDLE);
  assign accept = tx.tx_valid && tx.tx_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= (timer_q == TIMER_MAX) ? '0 : timer_q + 1'b1;
  end

  // Requests arriving while a frame is in flight are dropped and counted, never queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q      <= '0;
      overrun_cnt <= 8'd0;
    end else begin
      if (start) snap_q <= probe;
      if (req && (state_q != IDLE) && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dig_q   <= dig_d;
    end
  end

  always_comb begin
    label    = LABELS[int'(ch_q)*8 +: 8];
    nib      = snap_q[(int'(ch_q)*CH_HEX + int'(dig_q))*4 +: 4];
    hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dig_d   = dig_q;
    data    = 8'h00;
    case (state_q)
      IDLE: if (req) begin
        state_d = LABEL;
        ch_d    = '0;
      end
      LABEL: begin
        data = label;
        if (accept) state_d = COLON;
      end
      COLON: begin
        data = 8'h3A;
        if (accept) begin
          state_d = DIGIT;
          dig_d   = DIG_TOP;
        end
      end
      DIGIT: begin
        data = hex_char;
        if (accept) begin
          if (dig_q == '0) state_d = SEP;
          else             dig_d   = dig_q - 1'b1;
        end
      end
      SEP: begin
        data = (ch_q == CH_LAST) ? 8'h0D : 8'h20;
        if (accept) begin
          if (ch_q == CH_LAST) state_d = LF;
          else begin
            state_d = LABEL;
            ch_d    = ch_q + 1'b1;
          end
        end
      end
      LF: begin
        data = 8'h0A;
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the state flop, so reset clears them asynchronously.
  assign tx.tx_valid = (state_q != IDLE);
  assign tx.tx_data  = data;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_uart_probe_fmt.sv
// Directed self-checking bench for uart_probe_fmt with NUM_CH=2, CH_HEX=3, labels X/Y, PERIOD=100.
module tb_uart_probe_fmt;
  localparam int NUM_CH = 2;
  localparam int CH_HEX = 3;
  localparam int PERIOD = 100;
  localparam int FLEN   = NUM_CH * (CH_HEX + 3) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        trig = 1'b0;
  logic        tx_ready = 1'b1;
  logic [23:0] probe = 24'h0FF1A3;
  logic        busy;
  logic [7:0]  overrun_cnt;

  int checks = 0;
  int errors = 0;
  int m_timer;
  logic [7:0] rx_q[$];
  int rx_busy;
  int rx_stall_err;

  uart_probe_fmt_if tx_if ();
  assign tx_if.tx_ready = tx_ready;

  uart_probe_fmt #(
    .NUM_CH(NUM_CH), .CH_HEX(CH_HEX), .PERIOD(PERIOD), .LABELS(16'h5958)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .trig(trig), .probe(probe),
    .tx(tx_if), .busy(busy), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // Independent model of the free-running snapshot timer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_timer <= 0;
    else        m_timer <= (m_timer == PERIOD - 1) ? 0 : m_timer + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Collects one frame starting at a negedge; only records, never judges.
  task automatic get_frame(input bit toggle);
    logic [7:0] held = 8'h00;
    bit stalled = 1'b0;
    rx_q.delete();
    rx_busy = 0;
    rx_stall_err = 0;
    for (int w = 0; w < 300 && tx_if.tx_valid !== 1'b1; w++) @(negedge clk);
    for (int k = 0; k < 400 && rx_q.size() < FLEN; k++) begin
      tx_ready = toggle ? (k % 4 == 3) : 1'b1;
      if (busy === 1'b1) rx_busy++;
      if (tx_if.tx_valid === 1'b1) begin
        if (stalled && tx_if.tx_data !== held) rx_stall_err++;
        if (tx_ready) begin
          rx_q.push_back(tx_if.tx_data);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = tx_if.tx_data;
        end
      end
      @(negedge clk);
    end
    tx_ready = 1'b1;
  endtask

  task automatic wait_timer_max();
    for (int w = 0; w < 2 * PERIOD && m_timer != PERIOD - 1; w++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", tx_if.tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_overrun got %0d exp 0", overrun_cnt); end
    checks++; if (tx_if.tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", tx_if.tx_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_periodic_frame();
    string exp = "X:1A3 Y:0FF\r\n";
    enable = 1'b1;
    wait_timer_max();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pre_tick_busy got %b exp 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tick_start_busy got %b exp 1", busy); end
    checks++; if (tx_if.tx_data !== 8'h58) begin errors++; $display("FAIL tick_first_byte got %h exp 58", tx_if.tx_data); end
    get_frame(1'b0);
    checks++; if (rx_q.size() != FLEN) begin errors++; $display("FAIL frame_len got %0d exp %0d", rx_q.size(), FLEN); end
    for (int i = 0; i < rx_q.size() && i < FLEN; i++) begin
      checks++; if (rx_q[i] !== 8'(exp[i])) begin errors++; $display("FAIL frame_byte%0d got %h exp %h", i, rx_q[i], 8'(exp[i])); end
    end
    checks++; if (rx_busy != FLEN) begin errors++; $display("FAIL busy_cycles got %0d exp %0d", rx_busy, FLEN); end
    checks++; if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL frame_end got busy=%b valid=%b exp 0 0", busy, tx_if.tx_valid); end
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL frame_overrun got %0d exp 0", overrun_cnt); end
  endtask

  task automatic test_tick_and_trig();
    int extra = 0;
    wait_timer_max();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    enable = 1'b0;
    get_frame(1'b0);
    checks++; if (rx_q.size() != FLEN) begin errors++; $display("FAIL simul_len got %0d exp %0d", rx_q.size(), FLEN); end
    for (int k = 0; k < 30; k++) begin
      if (busy !== 1'b0) extra++;
      @(negedge clk);
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL simul_second_frame got %0d busy cycles exp 0", extra); end
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL simul_overrun got %0d exp 0", overrun_cnt); end
  endtask

  task automatic test_backpressure();
    string exp = "X:1A3 Y:0FF\r\n";
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    get_frame(1'b1);
    checks++; if (rx_q.size() != FLEN) begin errors++; $display("FAIL bp_len got %0d exp %0d", rx_q.size(), FLEN); end
    for (int i = 0; i < rx_q.size() && i < FLEN; i++) begin
      checks++; if (rx_q[i] !== 8'(exp[i])) begin errors++; $display("FAIL bp_byte%0d got %h exp %h", i, rx_q[i], 8'(exp[i])); end
    end
    checks++; if (rx_stall_err != 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", rx_stall_err); end
  endtask

  task automatic test_overrun();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    fork
      get_frame(1'b0);
      begin
        repeat (3) begin
          @(negedge clk); trig = 1'b1;
          @(negedge clk); trig = 1'b0;
        end
      end
    join
    checks++; if (rx_q.size() != FLEN) begin errors++; $display("FAIL ovr_len got %0d exp %0d", rx_q.size(), FLEN); end
    checks++; if (overrun_cnt !== 8'd3) begin errors++; $display("FAIL ovr_count got %0d exp 3", overrun_cnt); end
  endtask

  task automatic test_probe_change();
    string exp = "X:C40 Y:5E7\r\n";
    probe = 24'h5E7C40;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    probe = 24'hFFFFFF;
    get_frame(1'b0);
    checks++; if (rx_q.size() != FLEN) begin errors++; $display("FAIL snap_len got %0d exp %0d", rx_q.size(), FLEN); end
    for (int i = 0; i < rx_q.size() && i < FLEN; i++) begin
      checks++; if (rx_q[i] !== 8'(exp[i])) begin errors++; $display("FAIL snap_byte%0d got %h exp %h", i, rx_q[i], 8'(exp[i])); end
    end
    probe = 24'h0FF1A3;
  endtask

  task automatic test_saturate();
    tx_ready = 1'b0;
    trig = 1'b1;
    repeat (302) @(negedge clk);
    trig = 1'b0;
    checks++; if (overrun_cnt !== 8'd255) begin errors++; $display("FAIL sat_count got %0d exp 255", overrun_cnt); end
    get_frame(1'b0);
    checks++; if (rx_q.size() != FLEN) begin errors++; $display("FAIL sat_drain_len got %0d exp %0d", rx_q.size(), FLEN); end
    checks++; if (overrun_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", overrun_cnt); end
  endtask

  task automatic test_mid_reset();
    string exp = "X:1A3 Y:0FF\r\n";
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", tx_if.tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL rst_overrun got %0d exp 0", overrun_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_no_resume got %b exp 0", busy); end
    get_frame(1'b0);
    checks++; if (rx_q.size() != FLEN) begin errors++; $display("FAIL rst_frame_len got %0d exp %0d", rx_q.size(), FLEN); end
    for (int i = 0; i < rx_q.size() && i < FLEN; i++) begin
      checks++; if (rx_q[i] !== 8'(exp[i])) begin errors++; $display("FAIL rst_byte%0d got %h exp %h", i, rx_q[i], 8'(exp[i])); end
    end
  endtask

  task automatic test_periodic_count();
    int frames = 0;
    logic prev = 1'b0;
`ifdef UART_PROBE_DELTA_EN
    int exp_const = 0;
`else
    int exp_const = 5;
`endif
    for (int w = 0; w < 2 * PERIOD && m_timer != 50; w++) @(negedge clk);
    for (int k = 0; k < 5 * PERIOD; k++) begin
      if (busy === 1'b1 && !prev) frames++;
      prev = busy;
      @(negedge clk);
    end
    checks++; if (frames != exp_const) begin errors++; $display("FAIL const_probe_frames got %0d exp %0d", frames, exp_const); end
    probe[0] = ~probe[0];
    frames = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (busy === 1'b1 && !prev) frames++;
      prev = busy;
      @(negedge clk);
    end
    checks++; if (frames != 1) begin errors++; $display("FAIL changed_probe_frames got %0d exp 1", frames); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_periodic_frame();
    test_tick_and_trig();
    test_backpressure();
    test_overrun();
    test_probe_change();
    test_saturate();
    test_mid_reset();
    test_periodic_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_probe_fmt.md
Name: uart_probe_fmt

Overview:
- Parametrised telemetry formatter for the MPEG2 core's UART debug path.
- Snapshots a packed vector of NUM_CH probe channels on a periodic tick or an external trigger.
- Emits one ASCII frame per snapshot as a byte stream with a valid/ready handshake, feeding the existing uart_tx instance.
- Replaces hand-written per-signal print case tables with a label/width-generic engine, and adds overrun accounting.

Parameters:
- NUM_CH, 8, number of probe channels (1..32).
- CH_HEX, 4, hex digits per channel (1..8); channel width = 4*CH_HEX bits.
- PERIOD, 27000000, clk cycles between periodic snapshots (>= 2).
- LABELS, 64'h0, packed ASCII label bytes; channel n label = LABELS[8n+7:8n].

Ports:
- clk  in  1  system clock (27 MHz in the core).
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  periodic snapshots allowed when high.
- trig  in  1  single-cycle request for an immediate snapshot.
- probe  in  NUM_CH*CH_HEX*4  channel n = probe[n*4*CH_HEX +: 4*CH_HEX].
- tx_data  out  8  ASCII byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts a byte when tx_valid && tx_ready.
- busy  out  1  frame in progress.
- overrun_cnt  out  8  saturating count of dropped snapshot requests.

Behaviour:
- Reset (async, rst_n low): tx_valid=0, tx_data=0, busy=0, overrun_cnt=0, timer=0, state IDLE, all indices 0, snapshot register 0.
- Timer counts 0..PERIOD-1 and wraps. It counts whether or not enable is high. tick = (timer==PERIOD-1) && enable.
- req = tick || trig. Simultaneous tick and trig = one request.
- In IDLE with req: on the same edge, latch probe into the snapshot register, set busy=1, and go to LABEL with ch=0. The first byte is valid on the next cycle.
- req while busy, including the cycle the frame's last byte is accepted: request dropped; overrun_cnt += 1, saturating at 255. No queueing.
- Frame, per channel ch = 0..NUM_CH-1 in order: label byte, ':', CH_HEX hex digits MSB-first, then ' '. After the last channel, ' ' is replaced by '\r'; then '\n' follows.
- Frame length = NUM_CH*(CH_HEX+3)+1 bytes.
- Hex digits are 0-9 then A-F, uppercase.
- States: IDLE, LABEL, COLON, DIGIT (dig counts CH_HEX-1 down to 0), SEP, LF.
  - SEP emits ' ', or '\r' when ch==NUM_CH-1.
  - SEP with ch<NUM_CH-1 goes to LABEL with ch+1.
  - SEP with ch==NUM_CH-1 goes to LF.
  - LF goes to IDLE.
- Handshake:
  - Each state drives tx_valid=1 and its byte.
  - It advances only on the cycle tx_valid && tx_ready.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - Back-to-back bytes are allowed, giving 1 byte/cycle when tx_ready stays high.
- On acceptance of '\n': tx_valid=0 and busy=0 on the next cycle. A req on that following cycle starts a new frame.
- Probe changes during a frame do not affect it; the output comes from the snapshot register only.
- rst_n asserted mid-frame: the frame is abandoned immediately, with no partial completion.

Optional Feature:
- Macro: UART_PROBE_DELTA_EN.
- When defined:
  - Periodic ticks start a frame only if the new probe value differs from the last transmitted snapshot.
  - trig always starts a frame.
  - A suppressed tick does not count as overrun.
  - The first tick after reset always prints.
- When undefined: every req prints, as described above. No compare logic and no extra storage.

Test Plan:
- NUM_CH=2, CH_HEX=3, LABELS={"Y","X"}, PERIOD=100, probe={12'h0FF,12'h1A3}, tx_ready=1, enable=1 -> at timer wrap, bytes "X:1A3 Y:0FF\r\n" (13 bytes) on consecutive cycles; busy high for exactly 13 cycles.
- Same config with tx_ready toggling 1-of-4 cycles -> identical byte sequence; tx_data never changes while valid&&!ready.
- trig pulsed mid-frame 3 times -> frame unaffected, overrun_cnt=3; 300 dropped requests -> overrun_cnt=255.
- trig and tick in the same cycle -> exactly one frame, overrun_cnt unchanged.
- probe changes after the snapshot edge -> frame still prints the latched value.
- rst_n low at byte 5 -> tx_valid=0, busy=0 asynchronously; next tick prints a full frame.
- UART_PROBE_DELTA_EN with constant probe over 5 periods -> exactly one frame; changing one bit -> one more frame at the next tick.
